cnn_frame_sequencer: RTL
========================

Name: cnn_frame_sequencer

Overview:
- Frame-level controller in front of cnn_top. Accepts one H×W 8-bit image row-by-row from an upstream valid/ready source and paces those rows into the layer-1 line buffer (buffer_1_valid_i / input_data).
- Waits for the dense result, then runs a serial argmax over the 7 logits.
- Reports class, done, timeout and protocol-error status to the system controller.

Parameters:
- H, 24, rows per frame
- W, 24, pixels per row
- DATA_WIDTH, 8, bits per pixel and per logit
- NUM_CLASSES, 7, dense outputs
- ROW_GAP, 4, minimum idle cycles between consecutive row pushes (≥1)
- TIMEOUT, 65535, max cycles to wait for dense_valid_i after last row

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start_i  in  1  frame start pulse; ignored unless idle
- row_valid_i  in  1  upstream row available
- row_data_i  in  W*DATA_WIDTH  upstream row, pixel 0 in LSBs
- row_ready_o  out  1  sequencer accepts a row this cycle
- row_data_o  out  W*DATA_WIDTH  to cnn_top input_data
- row_valid_o  out  1  to cnn_top buffer_1_valid_i, one-cycle pulse per row
- dense_valid_i  in  1  from cnn_top dense_valid
- dense_data_i  in  NUM_CLASSES*DATA_WIDTH  from cnn_top dense_out, class 0 in LSBs, signed
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at frame end
- class_o  out  3  winning class index, valid from done_o onward
- max_o  out  DATA_WIDTH  winning logit
- timeout_o  out  1  sticky until next start; set when no result arrived
- err_o  out  1  sticky until next start; set on dense_valid_i outside WAIT_RES
- row_cnt_o  out  $clog2(H+1)  rows pushed in current frame

Behaviour:
- Reset (resetn=0 at posedge): state IDLE, all outputs 0, row_data_o=0, counters 0. Reset mid-frame aborts immediately; no done_o is produced.
- IDLE:
  - start_i=1 → clear row_cnt, timeout_o, err_o, class_o, max_o; go to FETCH next cycle.
  - start_i while not IDLE has no effect.
- FETCH:
  - row_ready_o=1, driven combinationally from state.
  - On row_valid_i & row_ready_o: latch row_data_i into row_data_o and go to PUSH.
  - row_data_o holds its value until the next accepted row.
- PUSH:
  - row_valid_o=1 for exactly this cycle; row_cnt increments.
  - If row_cnt (new value) == H → WAIT_RES, clearing the timeout counter. Otherwise → GAP.
- GAP:
  - Count ROW_GAP cycles with row_ready_o=0, then → FETCH.
  - Minimum push-to-push spacing is therefore ROW_GAP+2 cycles.
- WAIT_RES:
  - On dense_valid_i: latch dense_data_i into a logit register and → ARGMAX.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: set timeout_o, set class_o=7 and max_o=0, → DONE.
- ARGMAX:
  - Serial scan, one logit per cycle, index 0..NUM_CLASSES-1 (7 cycles).
  - Index 0 initialises max/class.
  - A later logit replaces the current max only if strictly greater (signed compare), so ties keep the lower index.
  - After the last index → DONE.
- DONE: done_o=1 for one cycle → IDLE. class_o, max_o, timeout_o and err_o hold until the next accepted start_i.
- Protocol error: dense_valid_i in any state other than WAIT_RES sets err_o. Data is ignored and the state is unaffected.
- Simultaneous dense_valid_i and timeout terminal count: the result wins; timeout_o is not set.
- Latency from the last row push to done_o with an immediate dense_valid_i: 1 (PUSH→WAIT_RES) + 1 + 7 + 1 cycles.
- Counters saturate, never wrap. row_cnt never exceeds H.

Decomposition:
- Shared package cnn_pkg holds:
  - state encoding (IDLE, FETCH, PUSH, GAP, WAIT_RES, ARGMAX, DONE)
  - NUM_CLASSES
  - INVALID_CLASS=3'd7
  - DATA_WIDTH default
- One natural sub-module: serial_argmax. Inputs: start, logits vector. Outputs: idx, max, done; signed, strict-greater compare. It is reusable by later dense-layer checks.

Test Plan:
- Nominal frame: start_i, upstream always valid with row r filled with value r.
  - Expect 24 row_valid_o pulses spaced 6 cycles apart, each carrying the matching row_data_o.
  - Then dense_valid_i with logits {0,5,-3,9,2,9,1}: done_o after 9 cycles, class_o=3, max_o=9.
- Backpressure: row_valid_i low for 10 cycles before row 5.
  - Expect row_ready_o held high, no row_valid_o during the stall, row_cnt_o=5 until the handshake.
- Timeout with TIMEOUT=100, no dense_valid_i.
  - Expect timeout_o=1, class_o=7, done_o exactly 101 cycles after entering WAIT_RES.
- Spurious result: dense_valid_i during FETCH of row 3.
  - Expect err_o=1, frame continues, 24 pushes still occur.
- Negative logits {-8,-2,-2,-128,-5,-7,-3}: expect class_o=1, max_o=-2 (tie keeps the lower index).
- Reset at row 10 and start_i while busy:
  - Reset gives busy_o=0, row_cnt_o=0, no done_o.
  - A mid-frame start_i leaves row_cnt_o unchanged.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN frame front-end blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the frame-sequencer state encoding, the default logit geometry and
// the class index reported when no dense result was obtained.
package cnn_pkg;

  // Default geometry of the dense layer output.
  localparam int CNN_DATA_WIDTH  = 8;
  localparam int CNN_NUM_CLASSES = 7;

  // Class index reported when the frame ended without a dense result.
  localparam logic [2:0] INVALID_CLASS = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_PUSH     = 3'd2,
    S_GAP      = 3'd3,
    S_WAIT_RES = 3'd4,
    S_ARGMAX   = 3'd5,
    S_DONE     = 3'd6
  } seq_state_e;

endpackage

// File: rtl/serial_argmax.sv
// Serial signed argmax over a packed logit vector, one element per cycle.
// Latency: start_i at cycle s -> done_o pulse at s+NUM_CLASSES+1.
// Backpressure: none; logits_i must stay stable while the scan runs.
//
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   start_i       begin a scan (restarts a scan already in flight)
//   logits_i      NUM_CLASSES signed values, element 0 in the LSBs
//   idx_o, max_o  index and value of the largest element (final at done_o)
//   done_o        one-cycle pulse when the scan has covered every element
module serial_argmax import cnn_pkg::*; #(
  parameter int NUM_CLASSES = CNN_NUM_CLASSES,
  parameter int DATA_WIDTH  = CNN_DATA_WIDTH,
  parameter int IDX_W       = 3
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start_i,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] logits_i,
  output logic [IDX_W-1:0]                  idx_o,
  output logic [DATA_WIDTH-1:0]             max_o,
  output logic                              done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  logic signed [DATA_WIDTH-1:0] logit_arr [NUM_CLASSES];

  genvar g;
  generate
    for (g = 0; g < NUM_CLASSES; g++) begin : g_unpack
      assign logit_arr[g] = logits_i[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic                         run_q, run_d;
  logic                         done_q, done_d;
  logic [IDX_W-1:0]             scan_q, scan_d;
  logic [IDX_W-1:0]             best_idx_q, best_idx_d;
  logic signed [DATA_WIDTH-1:0] best_q, best_d;
  logic signed [DATA_WIDTH-1:0] cur;

  always_comb begin
    run_d      = run_q;
    scan_d     = scan_q;
    best_idx_d = best_idx_q;
    best_d     = best_q;
    done_d     = 1'b0;
    cur        = logit_arr[scan_q];

    if (start_i) begin
      run_d  = 1'b1;
      scan_d = '0;
    end else if (run_q) begin
      // Element 0 seeds the running max; later elements must be strictly
      // greater so that ties resolve to the lowest index.
      if (scan_q == '0 || cur > best_q) begin
        best_d     = cur;
        best_idx_d = scan_q;
      end
      if (scan_q == LAST_IDX) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        scan_d = scan_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      scan_q     <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
    end else begin
      run_q      <= run_d;
      done_q     <= done_d;
      scan_q     <= scan_d;
      best_idx_q <= best_idx_d;
      best_q     <= best_d;
    end
  end

  assign idx_o  = best_idx_q;
  assign max_o  = best_q;
  assign done_o = done_q;

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame controller: paces H upstream rows into the CNN, then argmaxes the dense result.
// Latency: last row push -> done_o = 10 cycles with an immediate result; row pushes >= ROW_GAP+2 apart.
// Backpressure: row_ready_o only in FETCH; an idle upstream simply stretches FETCH.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   start_i                      frame start pulse, honoured only when idle
//   row_valid_i/row_data_i       upstream row stream, handshake with row_ready_o
//   row_valid_o/row_data_o       one-cycle push of the held row towards the line buffer
//   dense_valid_i/dense_data_i   dense layer result (signed logits, class 0 in LSBs)
//   busy_o, done_o               frame in progress / one-cycle end-of-frame pulse
//   class_o, max_o               winning class and logit, held until the next start
//   timeout_o, err_o             sticky status, cleared by the next start
//   row_cnt_o                    rows pushed in the current frame
module cnn_frame_sequencer import cnn_pkg::*; #(
  parameter int H           = 24,
  parameter int W           = 24,
  parameter int DATA_WIDTH  = CNN_DATA_WIDTH,
  parameter int NUM_CLASSES = CNN_NUM_CLASSES,
  parameter int ROW_GAP     = 4,
  parameter int TIMEOUT     = 65535
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start_i,
  input  logic                              row_valid_i,
  input  logic [W*DATA_WIDTH-1:0]           row_data_i,
  output logic                              row_ready_o,
  output logic [W*DATA_WIDTH-1:0]           row_data_o,
  output logic                              row_valid_o,
  input  logic                              dense_valid_i,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] dense_data_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [2:0]                        class_o,
  output logic [DATA_WIDTH-1:0]             max_o,
  output logic                              timeout_o,
  output logic                              err_o,
  output logic [$clog2(H+1)-1:0]            row_cnt_o
);

  localparam int RCW = $clog2(H + 1);
  localparam int GW  = $clog2(ROW_GAP + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [RCW-1:0] ROWS_FULL = RCW'(H);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(ROW_GAP - 1);
  localparam logic [TW-1:0]  TMO_MAX   = TW'(TIMEOUT);

  seq_state_e                        state_q, state_d;
  logic [W*DATA_WIDTH-1:0]           row_data_q, row_data_d;
  logic [RCW-1:0]                    row_cnt_q, row_cnt_d;
  logic [RCW-1:0]                    row_cnt_inc;
  logic [GW-1:0]                     gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]                     tmo_cnt_q, tmo_cnt_d;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] logit_q, logit_d;
  logic [2:0]                        class_q, class_d;
  logic [DATA_WIDTH-1:0]             max_q, max_d;
  logic                              timeout_q, timeout_d;
  logic                              err_q, err_d;

  logic                              am_start;
  logic [2:0]                        am_idx;
  logic [DATA_WIDTH-1:0]             am_max;
  logic                              am_done;

  // The scan is launched in the same cycle the logits are captured; the
  // argmax only starts reading one cycle later, by which time logit_q holds them.
  serial_argmax #(
    .NUM_CLASSES (NUM_CLASSES),
    .DATA_WIDTH  (DATA_WIDTH),
    .IDX_W       (3)
  ) u_argmax (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (am_start),
    .logits_i (logit_q),
    .idx_o    (am_idx),
    .max_o    (am_max),
    .done_o   (am_done)
  );

  // Row count saturates at H so a stray extra push can never wrap it.
  assign row_cnt_inc = (row_cnt_q == ROWS_FULL) ? row_cnt_q : row_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    row_data_d  = row_data_q;
    row_cnt_d   = row_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    logit_d     = logit_q;
    class_d     = class_q;
    max_d       = max_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    am_start    = 1'b0;
    row_ready_o = 1'b0;
    row_valid_o = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          row_cnt_d = '0;
          timeout_d = 1'b0;
          err_d     = 1'b0;
          class_d   = '0;
          max_d     = '0;
          state_d   = S_FETCH;
        end
      end

      S_FETCH: begin
        row_ready_o = 1'b1;
        if (row_valid_i) begin
          row_data_d = row_data_i;
          state_d    = S_PUSH;
        end
      end

      S_PUSH: begin
        row_valid_o = 1'b1;
        row_cnt_d   = row_cnt_inc;
        if (row_cnt_inc == ROWS_FULL) begin
          tmo_cnt_d = '0;
          state_d   = S_WAIT_RES;
        end else begin
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_FETCH;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      S_WAIT_RES: begin
        // A result arriving on the terminal-count cycle takes priority.
        if (dense_valid_i) begin
          logit_d  = dense_data_i;
          am_start = 1'b1;
          state_d  = S_ARGMAX;
        end else if (tmo_cnt_q == TMO_MAX) begin
          timeout_d = 1'b1;
          class_d   = INVALID_CLASS;
          max_d     = '0;
          state_d   = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_ARGMAX: begin
        if (am_done) begin
          class_d = am_idx;
          max_d   = am_max;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A result outside the wait window is flagged but otherwise ignored.
    if (dense_valid_i && (state_q != S_WAIT_RES)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      row_data_q <= '0;
      row_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      logit_q    <= '0;
      class_q    <= '0;
      max_q      <= '0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_data_q <= row_data_d;
      row_cnt_q  <= row_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      logit_q    <= logit_d;
      class_q    <= class_d;
      max_q      <= max_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign row_data_o = row_data_q;
  assign row_cnt_o  = row_cnt_q;
  assign class_o    = class_q;
  assign max_o      = max_q;
  assign timeout_o  = timeout_q;
  assign err_o      = err_q;

endmodule
